// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory controller.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic {INIT, IDLE} state_t;

  // Stores only have signed size codes; loads also take the unsigned ones.
  function automatic logic f3_legal(input logic [2:0] f3, input logic we);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) begin
      ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the MEM stage and the data-memory controller.
interface dmem_if #(
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_fault;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/dmem_bram.sv
// Word-organised single-port RAM with per-byte write enables and a registered,
// read-first output so it maps onto block RAM.
module dmem_bram #(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: optional clear-after-reset, fault checking, store
// lane steering and load extraction/extension around dmem_bram.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DEPTH          = 2**(ADDR_W-2),
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic   clk,
  input  logic   rst_n,
  dmem_if.slave  bus
);

  localparam int     AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam state_t RESET_STATE = CLEAR_ON_RESET ? INIT : IDLE;

  state_t            state, state_nxt;
  logic [AW-1:0]     init_cnt, init_cnt_nxt;
  logic              accept;
  logic              fault;
  logic [ADDR_W-3:0] word_idx;
  logic [1:0]        lane;
  logic [AW-1:0]     ram_addr;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [3:0]        store_be;
  logic [31:0]       store_data;
  logic              rsp_load;
  logic [1:0]        rsp_lane;
  logic [2:0]        rsp_f3;
  logic [31:0]       shifted;

  assign word_idx      = bus.req_addr[ADDR_W-1:2];
  assign lane          = bus.req_addr[1:0];
  assign bus.req_ready = (state == IDLE) && rst_n;
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    fault = 1'b0;
    if (32'(word_idx) >= 32'(DEPTH)) begin
      fault = 1'b1;
    end
    if (!f3_legal(bus.req_funct3, bus.req_we)) begin
      fault = 1'b1;
    end
    if (((bus.req_funct3 == F3_H) || (bus.req_funct3 == F3_HU)) && lane[0]) begin
      fault = 1'b1;
    end
    if ((bus.req_funct3 == F3_W) && (lane != 2'd0)) begin
      fault = 1'b1;
    end
  end

  // Sub-word stores replicate the data across lanes; the byte enables pick one.
  always_comb begin
    store_be   = 4'b0000;
    store_data = bus.req_wdata;
    case (bus.req_funct3)
      F3_B: begin
        store_be   = 4'b0001 << lane;
        store_data = {4{bus.req_wdata[7:0]}};
      end
      F3_H: begin
        store_be   = 4'b0011 << lane;
        store_data = {2{bus.req_wdata[15:0]}};
      end
      F3_W: begin
        store_be   = 4'b1111;
      end
      default: begin
        store_be   = 4'b0000;
      end
    endcase
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    ram_addr     = word_idx[AW-1:0];
    ram_be       = 4'b0000;
    ram_wdata    = store_data;
    case (state)
      INIT: begin
        ram_addr     = init_cnt;
        ram_be       = 4'b1111;
        ram_wdata    = 32'd0;
        init_cnt_nxt = init_cnt + 1'b1;
        if (init_cnt == AW'(DEPTH-1)) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (accept && bus.req_we && !fault) begin
          ram_be = store_be;
        end
      end
      default: state_nxt = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= RESET_STATE;
      init_cnt      <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_fault <= 1'b0;
      rsp_load      <= 1'b0;
      rsp_lane      <= 2'd0;
      rsp_f3        <= 3'd0;
    end else begin
      state         <= state_nxt;
      init_cnt      <= init_cnt_nxt;
      bus.rsp_valid <= accept;
      bus.rsp_fault <= accept && fault;
      rsp_load      <= accept && !bus.req_we && !fault;
      if (accept) begin
        rsp_lane <= lane;
        rsp_f3   <= bus.req_funct3;
      end
    end
  end

  dmem_bram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bram (
    .clk   (clk),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // The RAM word arrives a cycle after acceptance; steer and extend it here.
  assign shifted = ram_rdata >> {rsp_lane, 3'b000};

  always_comb begin
    bus.rsp_rdata = 32'd0;
    if (rsp_load) begin
      case (rsp_f3)
        F3_B:    bus.rsp_rdata = {{24{shifted[7]}}, shifted[7:0]};
        F3_H:    bus.rsp_rdata = {{16{shifted[15]}}, shifted[15:0]};
        F3_W:    bus.rsp_rdata = ram_rdata;
        F3_BU:   bus.rsp_rdata = {24'd0, shifted[7:0]};
        F3_HU:   bus.rsp_rdata = {16'd0, shifted[15:0]};
        default: bus.rsp_rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with CLEAR_ON_RESET=1 and a 16-word array.
module tb_dmem_ctrl;

  localparam int ADDR_W = 16;
  localparam int DEPTH  = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  dmem_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_ctrl #(
    .ADDR_W         (ADDR_W),
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; drives one request for one edge and samples the response.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [15:0] addr,
                               input logic [31:0] wdata, output logic valid,
                               output logic [31:0] rdata, output logic fault);
    checkOutput("ready_before_req", 32'(bus.req_ready), 32'd1);
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    @(negedge clk);
    bus.req_valid  = 1'b0;
    valid = bus.rsp_valid;
    rdata = bus.rsp_rdata;
    fault = bus.rsp_fault;
  endtask

  task automatic expectResponse(input string tag, input logic we, input logic [2:0] f3,
                                input logic [15:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_fault);
    logic        v;
    logic [31:0] d;
    logic        f;
    applyStimulus(we, f3, addr, wdata, v, d, f);
    checkOutput({tag, "_valid"}, 32'(v), 32'd1);
    checkOutput({tag, "_rdata"}, d, exp_rdata);
    checkOutput({tag, "_fault"}, 32'(f), 32'(exp_fault));
  endtask

  task automatic waitInit(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput({tag, "_ready_low"}, 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    checkOutput({tag, "_ready_high"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = '0;
    bus.req_wdata  = 32'd0;

    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    checkOutput("rst_rsp_fault", 32'(bus.rsp_fault), 32'd0);

    rst_n = 1'b1;
    waitInit("init");
    expectResponse("lw_0_cleared", 1'b0, 3'd2, 16'h0000, 32'd0, 32'h00000000, 1'b0);

    expectResponse("sw_10",  1'b1, 3'd2, 16'h0010, 32'h87654321, 32'h00000000, 1'b0);
    expectResponse("lb_13",  1'b0, 3'd0, 16'h0013, 32'd0, 32'hFFFFFF87, 1'b0);
    expectResponse("lbu_13", 1'b0, 3'd4, 16'h0013, 32'd0, 32'h00000087, 1'b0);
    expectResponse("lh_12",  1'b0, 3'd1, 16'h0012, 32'd0, 32'hFFFF8765, 1'b0);
    expectResponse("lhu_12", 1'b0, 3'd5, 16'h0012, 32'd0, 32'h00008765, 1'b0);
    expectResponse("lb_10",  1'b0, 3'd0, 16'h0010, 32'd0, 32'h00000021, 1'b0);
    expectResponse("lhu_10", 1'b0, 3'd5, 16'h0010, 32'd0, 32'h00004321, 1'b0);

    expectResponse("sb_11",     1'b1, 3'd0, 16'h0011, 32'h123456AB, 32'h00000000, 1'b0);
    expectResponse("lw_10_sb",  1'b0, 3'd2, 16'h0010, 32'd0, 32'h8765AB21, 1'b0);
    expectResponse("sh_12",     1'b1, 3'd1, 16'h0012, 32'hFFFF1234, 32'h00000000, 1'b0);
    expectResponse("lw_10_sh",  1'b0, 3'd2, 16'h0010, 32'd0, 32'h1234AB21, 1'b0);

    expectResponse("lw_mis_2",    1'b0, 3'd2, 16'h0002, 32'd0, 32'h00000000, 1'b1);
    expectResponse("lw_4_a",      1'b0, 3'd2, 16'h0004, 32'd0, 32'h00000000, 1'b0);
    expectResponse("sh_mis_5",    1'b1, 3'd1, 16'h0005, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    expectResponse("lw_4_b",      1'b0, 3'd2, 16'h0004, 32'd0, 32'h00000000, 1'b0);
    expectResponse("st_f3_3",     1'b1, 3'd3, 16'h0004, 32'hA5A5A5A5, 32'h00000000, 1'b1);
    expectResponse("lw_4_c",      1'b0, 3'd2, 16'h0004, 32'd0, 32'h00000000, 1'b0);
    expectResponse("ld_f3_3",     1'b0, 3'd3, 16'h0004, 32'd0, 32'h00000000, 1'b1);
    expectResponse("sbu_store",   1'b1, 3'd4, 16'h0004, 32'h5A5A5A5A, 32'h00000000, 1'b1);
    expectResponse("lw_4_d",      1'b0, 3'd2, 16'h0004, 32'd0, 32'h00000000, 1'b0);
    expectResponse("sw_oor_40",   1'b1, 3'd2, 16'h0044, 32'hCAFEF00D, 32'h00000000, 1'b1);
    expectResponse("lw_4_e",      1'b0, 3'd2, 16'h0004, 32'd0, 32'h00000000, 1'b0);
    expectResponse("lw_oor_40",   1'b0, 3'd2, 16'h0040, 32'd0, 32'h00000000, 1'b1);
    expectResponse("lw_0_e",      1'b0, 3'd2, 16'h0000, 32'd0, 32'h00000000, 1'b0);

    // Back-to-back store then load to the same word.
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = 16'h0020;
    bus.req_wdata  = 32'hDEADBEEF;
    bus.req_valid  = 1'b1;
    @(negedge clk);
    checkOutput("b2b_sw_valid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("b2b_sw_rdata", bus.rsp_rdata, 32'd0);
    checkOutput("b2b_ready", 32'(bus.req_ready), 32'd1);
    bus.req_we     = 1'b0;
    bus.req_wdata  = 32'd0;
    @(negedge clk);
    bus.req_valid  = 1'b0;
    checkOutput("b2b_lw_valid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("b2b_lw_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    checkOutput("b2b_lw_fault", 32'(bus.rsp_fault), 32'd0);
    @(negedge clk);
    checkOutput("b2b_idle_valid", 32'(bus.rsp_valid), 32'd0);

    // Reset lands while a load response is pending.
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = 16'h0010;
    bus.req_valid  = 1'b1;
    @(negedge clk);
    bus.req_valid  = 1'b0;
    checkOutput("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("pre_rst_rdata", bus.rsp_rdata, 32'h1234AB21);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("mid_rst_rdata", bus.rsp_rdata, 32'd0);
    rst_n = 1'b1;
    waitInit("reinit");
    expectResponse("lw_10_reinit", 1'b0, 3'd2, 16'h0010, 32'd0, 32'h00000000, 1'b0);
    expectResponse("lw_20_reinit", 1'b0, 3'd2, 16'h0020, 32'd0, 32'h00000000, 1'b0);
    expectResponse("lw_3c_reinit", 1'b0, 3'd2, 16'h003C, 32'd0, 32'h00000000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
